// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// mem_arb : round-robin arbiter of a fetch port and a data port onto one
//           single-port memory. Optional counters: MEM_ARB_STATS_EN. Rev 1.0
// ============================================================================
module mem_arb #(
  parameter int DW = 128,
  parameter int AW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_addr,
  output logic            i_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   i_rsp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW/8-1:0] d_we,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_rsp_valid,
  input  logic            d_rsp_ready,
  output logic [DW-1:0]   d_rsp_data,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  input  logic [DW-1:0]   mem_dout,
  output logic [31:0]     stat_gnt0,
  output logic [31:0]     stat_gnt1,
  output logic [31:0]     stat_conflict
);

  logic          inflight0, inflight1;
  logic          hold_vld0, hold_vld1;
  logic          last1;
  logic [DW-1:0] hold0, hold1;
  logic          elig0, elig1, req0, req1, gnt0, gnt1;

  // A port may issue only if its previous response leaves the memory output this cycle.
  always_comb begin
    elig0 = !hold_vld0 && (!inflight0 || i_rsp_ready);
    elig1 = !hold_vld1 && (!inflight1 || d_rsp_ready);
    req0  = i_req_valid && elig0;
    req1  = d_req_valid && elig1;
    gnt0  = req0 && (!req1 || last1);
    gnt1  = req1 && (!req0 || !last1);
  end

  assign i_req_ready = gnt0;
  assign d_req_ready = gnt1;
  assign mem_en      = gnt0 | gnt1;
  assign mem_addr    = gnt1 ? d_addr : i_addr;
  assign mem_we      = gnt1 ? d_we : '0;
  assign mem_din     = d_wdata;

  assign i_rsp_valid = inflight0 | hold_vld0;
  assign i_rsp_data  = hold_vld0 ? hold0 : mem_dout;
  assign d_rsp_valid = inflight1 | hold_vld1;
  assign d_rsp_data  = hold_vld1 ? hold1 : mem_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight0 <= 1'b0;
      inflight1 <= 1'b0;
      hold_vld0 <= 1'b0;
      hold_vld1 <= 1'b0;
      last1     <= 1'b1;
    end else begin
      inflight0 <= gnt0;
      inflight1 <= gnt1 && (d_we == '0);
      hold_vld0 <= (hold_vld0 | inflight0) & !i_rsp_ready;
      hold_vld1 <= (hold_vld1 | inflight1) & !d_rsp_ready;
      if (gnt0 | gnt1) last1 <= gnt1;
    end
  end

  // Skid capture of the one-cycle memory output when the consumer stalls.
  always_ff @(posedge clk) begin
    if (inflight0 && !i_rsp_ready) hold0 <= mem_dout;
    if (inflight1 && !d_rsp_ready) hold1 <= mem_dout;
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] cnt_gnt0, cnt_gnt1, cnt_conflict;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_gnt0     <= 32'd0;
      cnt_gnt1     <= 32'd0;
      cnt_conflict <= 32'd0;
    end else begin
      if (gnt0) cnt_gnt0 <= cnt_gnt0 + 32'd1;
      if (gnt1) cnt_gnt1 <= cnt_gnt1 + 32'd1;
      if (i_req_valid && d_req_valid && elig0 && elig1)
        cnt_conflict <= cnt_conflict + 32'd1;
    end
  end

  assign stat_gnt0     = cnt_gnt0;
  assign stat_gnt1     = cnt_gnt1;
  assign stat_conflict = cnt_conflict;
`else
  assign stat_gnt0     = 32'd0;
  assign stat_gnt1     = 32'd0;
  assign stat_conflict = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// tb_mem_arb : directed stimulus with a queue scoreboard for mem_arb responses.
module tb_mem_arb;
  localparam int DW = 128;
  localparam int AW = 16;
  localparam int WB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
  logic [AW-1:0] d_addr;
  logic [WB-1:0] d_we;
  logic [DW-1:0] d_wdata, d_rsp_data;
  logic          mem_en;
  logic [WB-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [31:0]   stat_gnt0, stat_gnt1, stat_conflict;

  always #5 clk = ~clk;

  mem_arb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout),
    .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  bit            seen0 = 1'b0, seen1 = 1'b0;
  int            n_cmp = 0, n_bad = 0, cyc = 0;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  bit            mem_loaded = 1'b0;

  function automatic logic [DW-1:0] pat(input int i);
    logic [DW-1:0] r;
    logic [7:0]    b;
    b = i[7:0] ^ 8'hBA;
    for (int k = 0; k < WB; k++) r[8*k +: 8] = b + 8'(k);
    return r;
  endfunction

  // Single-port memory, registered read, byte-enabled write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      mem_dout <= mem[mem_addr[7:0]];
      for (int b = 0; b < WB; b++)
        if (mem_we[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  function automatic void check(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic mon(input int p, input logic v, input logic r, input logic [DW-1:0] d);
    exp_t  e;
    int    n;
    string nm;
    nm = (p == 0) ? "rsp0" : "rsp1";
    n  = (p == 0) ? q0.size() : q1.size();
    if (!v) return;
    if (n == 0) begin
      check({nm, "_unexpected"}, DW'(v), '0);
      return;
    end
    e = (p == 0) ? q0[0] : q1[0];
    if ((p == 0) ? !seen0 : !seen1) check({nm, "_latency"}, DW'(cyc), DW'(e.cyc + 1));
    if (p == 0) seen0 = 1'b1; else seen1 = 1'b1;
    if (r) begin
      check({nm, "_data"}, d, e.data);
      if (p == 0) begin void'(q0.pop_front()); seen0 = 1'b0; end
      else begin void'(q1.pop_front()); seen1 = 1'b0; end
    end else begin
      check({nm, "_held"}, d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, i_rsp_valid, i_rsp_ready, i_rsp_data);
      mon(1, d_rsp_valid, d_rsp_ready, d_rsp_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one request cycle against the expected grant and queues read responses.
  task automatic expect_req(input logic exp_i, input logic exp_d);
    @(negedge clk);
    check("i_req_ready", DW'(i_req_ready), DW'(exp_i));
    check("d_req_ready", DW'(d_req_ready), DW'(exp_d));
    check("mem_en", DW'(mem_en), DW'(exp_i | exp_d));
    check("mem_din", mem_din, d_wdata);
    if (exp_d) begin
      check("mem_addr", DW'(mem_addr), DW'(d_addr));
      check("mem_we", DW'(mem_we), DW'(d_we));
      if (d_we == '0) q1.push_back('{ref_mem[d_addr[7:0]], cyc});
    end else begin
      check("mem_we", DW'(mem_we), '0);
      if (exp_i) begin
        check("mem_addr", DW'(mem_addr), DW'(i_addr));
        q0.push_back('{ref_mem[i_addr[7:0]], cyc});
      end
    end
    tick();
  endtask

  task automatic check_stats(input int g0, input int g1, input int c);
    @(negedge clk);
`ifdef MEM_ARB_STATS_EN
    check("stat_gnt0", DW'(stat_gnt0), DW'(g0));
    check("stat_gnt1", DW'(stat_gnt1), DW'(g1));
    check("stat_conflict", DW'(stat_conflict), DW'(c));
`else
    check("stat_gnt0", DW'(stat_gnt0), DW'(g0 & 0));
    check("stat_gnt1", DW'(stat_gnt1), DW'(g1 & 0));
    check("stat_conflict", DW'(stat_conflict), DW'(c & 0));
`endif
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_addr = '0; i_rsp_ready = 1'b1;
    d_req_valid = 1'b0; d_addr = '0; d_we = '0; d_wdata = '0; d_rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    repeat (3) tick();
    @(negedge clk);
    check("rst_i_rsp_valid", DW'(i_rsp_valid), '0);
    check("rst_d_rsp_valid", DW'(d_rsp_valid), '0);
    check("rst_mem_en", DW'(mem_en), '0);
    check("rst_mem_we", DW'(mem_we), '0);
    tick();
    rst_n = 1'b1;
    check_stats(0, 0, 0);

    // Conflict: round-robin order p0, p1, p0.
    i_req_valid = 1'b1; i_addr = 16'h0001;
    d_req_valid = 1'b1; d_addr = 16'h0002; d_we = '0;
    expect_req(1'b1, 1'b0);
    expect_req(1'b0, 1'b1);
    expect_req(1'b1, 1'b0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (2) tick();
    check_stats(2, 1, 3);

    // Single fetch read.
    i_req_valid = 1'b1; i_addr = 16'h0010;
    expect_req(1'b1, 1'b0);
    i_req_valid = 1'b0;
    repeat (2) tick();

    // Streaming fetch reads.
    i_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_addr = AW'(i);
      expect_req(1'b1, 1'b0);
    end
    i_req_valid = 1'b0;
    repeat (2) tick();

    // Byte-enabled write then read-back.
    d_req_valid = 1'b1; d_addr = 16'h0005; d_we = 16'h000F;
    d_wdata = {{(DW-32){1'b1}}, 32'hDEADBEEF};
    expect_req(1'b0, 1'b1);
    for (int b = 0; b < 4; b++) ref_mem[5][8*b +: 8] = d_wdata[8*b +: 8];
    d_req_valid = 1'b0; d_we = '0;
    @(negedge clk);
    check("wr_no_rsp", DW'(d_rsp_valid), '0);
    check("wr_we_one_cycle", DW'(mem_we), '0);
    tick();
    d_req_valid = 1'b1; d_addr = 16'h0005;
    expect_req(1'b0, 1'b1);
    d_req_valid = 1'b0;
    repeat (2) tick();

    // Fetch backpressure while port 1 is served.
    i_req_valid = 1'b1; i_addr = 16'h0003;
    expect_req(1'b1, 1'b0);
    i_rsp_ready = 1'b0; i_addr = 16'h0006;
    d_req_valid = 1'b1; d_addr = 16'h0004; d_we = '0;
    expect_req(1'b0, 1'b1);
    d_req_valid = 1'b0;
    repeat (3) expect_req(1'b0, 1'b0);
    i_rsp_ready = 1'b1;
    expect_req(1'b0, 1'b0);
    expect_req(1'b1, 1'b0);
    i_req_valid = 1'b0;
    repeat (2) tick();
    check_stats(13, 4, 3);
    check("q0_drained", DW'(q0.size()), '0);
    check("q1_drained", DW'(q1.size()), '0);

    // Reset right after a read handshake discards its response.
    i_req_valid = 1'b1; i_addr = 16'h0007; i_rsp_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_i_req_ready", DW'(i_req_ready), DW'(1));
    tick();
    i_req_valid = 1'b0; rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("post_rst_i_rsp_valid", DW'(i_rsp_valid), '0);
    tick();
    check_stats(0, 0, 0);
    check("q0_final", DW'(q0.size()), '0);
    check("q1_final", DW'(q1.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter DW, default 128, memory line width in bits; multiple of 8.
REQ-002 SHALL have parameter AW, default 16, line address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports i_req_valid in 1, i_req_ready out 1, i_addr in AW: fetch read request (port 0, read-only).
REQ-006 SHALL have ports i_rsp_valid out 1, i_rsp_ready in 1, i_rsp_data out DW: fetch read response.
REQ-007 SHALL have ports d_req_valid in 1, d_req_ready out 1, d_addr in AW, d_we in DW/8, d_wdata in DW: data request (port 1); d_we==0 is a read, else byte-enabled write.
REQ-008 SHALL have ports d_rsp_valid out 1, d_rsp_ready in 1, d_rsp_data out DW: data read response.
REQ-009 SHALL have ports mem_en out 1, mem_we out DW/8, mem_addr out AW, mem_din out DW, mem_dout in DW: single-port memory with 1-cycle registered read.
REQ-010 SHALL have ports stat_gnt0, stat_gnt1, stat_conflict  out  32 each: performance counters.

Function
REQ-011 Request handshake on port p SHALL occur when req_valid_p && req_ready_p in the same cycle; at most one port SHALL be granted per cycle.
REQ-012 Port p SHALL be eligible when hold_vld_p==0 && (inflight_p==0 || rsp_ready_p==1); req_ready_p SHALL be 1 only for the granted port. The combinational path rsp_ready->req_ready is permitted.
REQ-013 With one eligible valid requester, it SHALL be granted. With both, grant SHALL go to the port not granted most recently (round-robin); the last-grant pointer SHALL update only on a handshake.
REQ-014 On a grant, mem_en=1 and mem_addr=granted address SHALL be driven the same cycle. mem_we SHALL be d_we on a port-1 grant and 0 otherwise. mem_din SHALL always be d_wdata. With no grant, mem_en=0 and mem_we=0.
REQ-015 A read handshake in cycle N SHALL set inflight_p. In cycle N+1, rsp_valid_p=1 and rsp_data_p=mem_dout (bypass).
REQ-016 If rsp_ready_p==0 in N+1, mem_dout SHALL be captured into the port-p hold register. hold_vld_p SHALL set, and rsp_valid_p/rsp_data_p SHALL then come from the hold register until rsp_ready_p==1.
REQ-017 Response data SHALL stay stable while rsp_valid_p && !rsp_ready_p; a later grant to the other port SHALL NOT corrupt it.
REQ-018 A port-1 write handshake SHALL produce no response and SHALL NOT set inflight_1.
REQ-019 Back-to-back reads on one port SHALL be sustainable at 1/cycle when rsp_ready_p is held at 1. Alternating ports SHALL sustain 1 access/cycle.
REQ-020 Responses per port SHALL be returned in request order; at most one outstanding response per port.

Reset
REQ-021 While rst_n==0 at a clock edge, the block SHALL clear inflight_0/1 and hold_vld_0/1, set the last-grant pointer to port 1 (port 0 wins the first conflict), and zero all stat counters.
REQ-022 Outputs during and after reset until the next handshake SHALL be: req_ready per REQ-012, rsp_valid 0, mem_en 0, mem_we 0.
REQ-023 Reset asserted mid-transaction SHALL discard in-flight and held responses; no response SHALL appear after deassertion for requests accepted before it.

Configuration
REQ-024 Macro MEM_ARB_STATS_EN: when defined, stat_gnt0/stat_gnt1 SHALL each increment per port-0/port-1 handshake. stat_conflict SHALL increment in every cycle where both req_valid are 1 and both ports are eligible. All three counters SHALL be 32-bit wrapping.
REQ-025 When MEM_ARB_STATS_EN is undefined, the stat ports SHALL still exist, tied to 0, with no counter logic.

Verification
REQ-026 Fetch read only: i_addr=0x0010, mem word 0x..AA, i_rsp_ready=1 -> i_req_ready=1 at N, i_rsp_valid=1 with data 0x..AA at N+1.
REQ-027 Simultaneous valid requests after reset with i_addr=0x1, d_addr=0x2 (read) held 3 cycles -> grants in order port0, port1, port0; stat_conflict=3 with MEM_ARB_STATS_EN.
REQ-028 Data write d_we=0x000F, d_wdata low word 0xDEADBEEF at 0x5, then read 0x5 -> mem_we=0x000F for one cycle, no d_rsp_valid for the write, read returns low word 0xDEADBEEF.
REQ-029 Backpressure: fetch read of 0x3, i_rsp_ready=0 for 4 cycles while port 1 reads 0x4 -> i_rsp_data stays mem[0x3], i_req_ready=0 throughout, and port 1 still served.
REQ-030 Streaming: 8 consecutive fetch reads 0x0..0x7 with i_rsp_ready=1 -> 8 handshakes in 8 cycles, responses in order, 1-cycle latency.
REQ-031 Reset mid-read: handshake at N, rst_n=0 at N+1 -> no i_rsp_valid after reset release, and stat counters read 0.
